aes_key_expander: RTL
=====================

# aes_key_expander

Parametrised, word-serial AES key expansion engine supporting AES-128, AES-192 and AES-256 via the `KEY_BITS` parameter. It expands a cipher key per FIPS-197 and streams round keys 0..NR one 128-bit key at a time over a valid/ready interface. Round constants are generated internally. It sits between the key-load logic and the round pipeline and replaces the fixed-128-bit, externally-RCON-driven key schedule.

## Interface
- `KEY_BITS`, 128: cipher key length; legal values 128, 192, 256.
  - NK = KEY_BITS/32.
  - NR = NK+6.
  - Total words generated is TW = 4*(NR+1).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start_i` in 1: single-cycle request to begin expansion; sampled only in IDLE.
- `key_i` in KEY_BITS: cipher key, sampled when start is accepted.
  - Word 0 is `key_i[KEY_BITS-1 -: 32]`, FIPS-197 big-endian byte order.
- `busy_o` out 1: high from the cycle after start acceptance until `done_o`.
- `rk_valid_o` out 1: a round key is held on `rk_o`.
- `rk_ready_i` in 1: consumer accepts `rk_o` when `rk_valid_o` and `rk_ready_i` are both high.
- `rk_o` out 128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
- `rk_idx_o` out 4: round number r (0..NR) of `rk_o`.
- `done_o` out 1: one-cycle pulse the cycle after the last key (r = NR) is accepted.

## Operation
- State machine: IDLE, EXPAND, DRAIN.
  - IDLE -> EXPAND on `start_i`. `key_i` is latched, the word counter i is set to 0 and Rcon is set to 0x01.
  - EXPAND -> DRAIN when word TW-1 has been produced into the assembly buffer.
  - DRAIN -> IDLE on acceptance of round NR; `done_o` pulses in that next cycle.
- Word generation: one word per enabled cycle, into an NK-deep sliding window holding w[i-NK..i-1].
  - i < NK: w[i] = key word i.
  - i mod NK == 0: w[i] = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} ^ w[i-NK]. Rcon then advances by xtime: multiply by 2 in GF(2^8), reduced with 0x1b.
  - NK == 8 and i mod 8 == 4: w[i] = SubWord(w[i-1]) ^ w[i-NK].
  - Otherwise: w[i] = w[i-1] ^ w[i-NK].
  - SubWord uses the existing 32-bit combinational `Sbox` module, instantiated once.
- Assembly buffer: collects 4 consecutive words.
  - When full, it transfers to the output register if the output register is empty or being accepted in the same cycle.
  - The generator stalls (i holds, window holds) when the assembly buffer is full and cannot transfer.
- `start_i` is ignored in EXPAND and DRAIN; there is no queuing.
- `rk_o` and `rk_idx_o` are stable while `rk_valid_o` is high and `rk_ready_i` is low.
- `rst` in any state returns the block to IDLE. Partial keys are discarded and no `done_o` is issued.

## Timing
- Reset values:
  - `busy_o` = 0, `rk_valid_o` = 0, `done_o` = 0.
  - `rk_o` = 0, `rk_idx_o` = 0.
  - State IDLE, i = 0, Rcon = 0x01.
- Start accepted at edge E0; w0..w3 are written at E1..E4.
- Round key 0: `rk_valid_o` = 1 after E4 (latency 4 cycles).
- With `rk_ready_i` held at 1:
  - A new round key every 4 cycles.
  - Round NR is valid after edge 4*(NR+1).
  - `done_o` pulses one cycle after its acceptance.
- Back-to-back acceptance must not lose or duplicate a round: a transfer and an acceptance in the same cycle are both honoured.
- Maximum stall is unbounded; no key is dropped while `rk_ready_i` is low.
- Next `start_i` is accepted in the cycle `done_o` is high (state is IDLE).

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1:
  - r0 = key.
  - r1 = a0fafe1788542cb123a339392a6c7605.
  - r10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 44.
  - `done_o` at cycle 45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - 13 round keys.
  - r12 = e98ba06f448c773c8ecc720401002202, `rk_idx_o` = 12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - r1 = 1f352c073b6108d72d9810a30914dff4.
  - r14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure: AES-128 with `rk_ready_i` toggled randomly, including 20-cycle low stretches:
  - The same 11 keys arrive in order.
  - `rk_o` is stable while stalled.
  - No gaps or duplicates in `rk_idx_o`.
- `start_i` pulsed mid-EXPAND with a different key -> ignored; output matches the first key.
- `rst` asserted after round 3 is accepted:
  - Next cycle `rk_valid_o` = 0, `busy_o` = 0, no `done_o`.
  - A fresh start produces the correct r0..r10 (Rcon restarts at 0x01).

Source files
------------

// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key expansion with internal Rcon generation.
// Streams round keys 0..NR as 128-bit words over a valid/ready handshake.

module Sbox (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit {~x,3'b111} downward: entry 0 is the top byte of the table.
  always_comb begin
    data_o = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      data_o[8*b +: 8] = SBOX_TABLE[{~data_i[8*b +: 8], 3'b111} -: 8];
    end
  end
endmodule

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [KEY_BITS-1:0] key_i,
  output logic                busy_o,
  output logic                rk_valid_o,
  input  logic                rk_ready_i,
  output logic [127:0]        rk_o,
  output logic [3:0]          rk_idx_o,
  output logic                done_o
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]          state_q, state_d;
  logic [5:0]          i_q, i_d;
  logic [2:0]          pos_q, pos_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [127:0]        asm_q, asm_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          xfer_idx_q, xfer_idx_d;
  logic [127:0]        rk_q, rk_d;
  logic [3:0]          rk_idx_q, rk_idx_d;
  logic                rk_valid_q, rk_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [31:0] prev_word, old_word, new_word, sbox_in, sbox_out;
  logic        first_pass, out_free, accept, gen, xfer_buf, xfer_byp;

  Sbox u_sbox (
    .data_i (sbox_in),
    .data_o (sbox_out)
  );

  // Next-word computation. The window holds w[i-NK] in its MSBs and w[i-1] in its
  // LSBs; while i < NK the window simply rotates, replaying the loaded key.
  always_comb begin
    prev_word  = win_q[31:0];
    old_word   = win_q[KEY_BITS-1 -: 32];
    first_pass = (i_q < 6'(NK));
    sbox_in    = (pos_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (first_pass) begin
      new_word = old_word;
    end else if (pos_q == 3'd0) begin
      new_word = sbox_out ^ {rcon_q, 24'h00_0000} ^ old_word;
    end else if ((NK == 8) && (pos_q == 3'd4)) begin
      new_word = sbox_out ^ old_word;
    end else begin
      new_word = prev_word ^ old_word;
    end
  end

  // Handshake qualifiers: the 4th word may bypass straight into the output register.
  always_comb begin
    out_free = !rk_valid_q || rk_ready_i;
    accept   = rk_valid_q && rk_ready_i;
    gen      = (state_q == S_EXPAND) && ((cnt_q != 3'd4) || out_free);
    xfer_buf = (cnt_q == 3'd4) && out_free;
    xfer_byp = gen && (cnt_q == 3'd3) && out_free;
  end

  // Generator, assembly buffer, output register and state sequencing.
  always_comb begin
    i_d        = i_q;
    pos_d      = pos_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    xfer_idx_d = xfer_idx_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (gen) begin
      win_d = {win_q[KEY_BITS-33:0], new_word};
      i_d   = i_q + 6'd1;
      pos_d = (pos_q == 3'(NK-1)) ? 3'd0 : pos_q + 3'd1;
      if (!first_pass && (pos_q == 3'd0)) begin
        rcon_d = xtime(rcon_q);
      end else begin
        rcon_d = rcon_q;
      end
    end else begin
      win_d = win_q;
    end

    if (xfer_byp) begin
      rk_d  = {asm_q[127:32], new_word};
      cnt_d = 3'd0;
    end else if (xfer_buf) begin
      rk_d          = asm_q;
      asm_d[127:96] = new_word;
      cnt_d         = gen ? 3'd1 : 3'd0;
    end else if (gen) begin
      asm_d[{~cnt_q[1:0], 5'b11111} -: 32] = new_word;
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (xfer_byp || xfer_buf) begin
      rk_valid_d = 1'b1;
      rk_idx_d   = xfer_idx_q;
      xfer_idx_d = xfer_idx_q + 4'd1;
    end else if (accept) begin
      rk_valid_d = 1'b0;
    end else begin
      rk_valid_d = rk_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_EXPAND;
          busy_d     = 1'b1;
          win_d      = key_i;
          i_d        = 6'd0;
          pos_d      = 3'd0;
          rcon_d     = 8'h01;
          cnt_d      = 3'd0;
          xfer_idx_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXPAND: begin
        if (gen && (i_q == 6'(TW-1))) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_EXPAND;
        end
      end
      S_DRAIN: begin
        if (accept && (rk_idx_q == 4'(NR))) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= 6'd0;
      pos_q      <= 3'd0;
      rcon_q     <= 8'h01;
      win_q      <= {KEY_BITS{1'b0}};
      asm_q      <= 128'h0;
      cnt_q      <= 3'd0;
      xfer_idx_q <= 4'd0;
      rk_q       <= 128'h0;
      rk_idx_q   <= 4'd0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      pos_q      <= pos_d;
      rcon_q     <= rcon_d;
      win_q      <= win_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      xfer_idx_q <= xfer_idx_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign rk_valid_o = rk_valid_q;
  assign rk_o       = rk_q;
  assign rk_idx_o   = rk_idx_q;
  assign done_o     = done_q;
endmodule
